// File: rtl/agc_spi_pkg.sv
// Shared types and defaults for the AGC SPI scheduler: FSM states, frame layout, default divider.
package agc_spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP
    } state_t;

    // Frame layout on the wire, MSB first: {R1W0, addr[6:0], data[7:0]}
    typedef struct packed {
        logic       rw;
        logic [6:0] addr;
        logic [7:0] data;
    } frame_t;

    localparam int unsigned DEFAULT_CLK_DIV = 4;

endpackage

// File: rtl/agc_spi_clkdiv.sv
// SCLK generator: toggles every CLK_DIV cycles while enabled, idles low, and flags the edge
// about to happen so the scheduler can act on the same main_clk edge.
module agc_spi_clkdiv
    import agc_spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = DEFAULT_CLK_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic sclk,
    output logic rise,
    output logic fall
);

    localparam int unsigned CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;
    logic          wrap;

    assign wrap = en && (cnt == LAST);
    assign rise = wrap && !sclk;
    assign fall = wrap && sclk;

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt  <= '0;
            sclk <= 1'b0;
        end else if (wrap) begin
            cnt  <= '0;
            sclk <= ~sclk;
        end else begin
            cnt  <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/agc_spi_sched.sv
// Two-requester round-robin SPI frame scheduler for the AGC loops.
// Optional readback (SDIO turnaround, MISO capture) is built when AGC_SPI_READBACK_EN is defined.
module agc_spi_sched
    import agc_spi_pkg::*;
#(
    parameter int unsigned CLK_DIV    = DEFAULT_CLK_DIV,
    parameter int unsigned FRAME_BITS = 16
) (
    input  logic        main_clk,
    input  logic        reg_reset,
    input  logic        req_a,
    input  logic        req_b,
    input  logic [15:0] cmd_a,
    input  logic [15:0] cmd_b,
    output logic        gnt_a,
    output logic        gnt_b,
    output logic        busy,
    output logic        done,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    output logic        spi_sclk,
    output logic        spi_csa_n,
    output logic        spi_csb_n,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output logic        sdio_t
);

    localparam int unsigned PW = $clog2(2 * CLK_DIV);
    localparam logic [PW-1:0] DIV_LAST = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] GAP_LAST = PW'(2 * CLK_DIV - 1);
    localparam logic [4:0]    BIT_LAST = 5'(FRAME_BITS - 1);

    state_t        state, state_d;
    logic [PW-1:0] pcnt;
    logic [4:0]    bit_cnt;
    logic [15:0]   sh;
    logic [15:0]   cmd_sel;
    logic          sel_b, prio_b;
    logic          grant_a, grant_b, hold_exit;
    logic          shifting, cs_active;
    logic          sclk_rise, sclk_fall;

    agc_spi_clkdiv #(.CLK_DIV(CLK_DIV)) u_clkdiv (
        .clk  (main_clk),
        .rst  (reg_reset),
        .en   (shifting),
        .sclk (spi_sclk),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    assign shifting  = (state == ST_SHIFT);
    assign cs_active = (state == ST_SETUP) || (state == ST_SHIFT) || (state == ST_HOLD);
    assign busy      = (state != ST_IDLE);
    assign spi_csa_n = !(cs_active && !sel_b);
    assign spi_csb_n = !(cs_active && sel_b);
    assign spi_mosi  = cs_active && sh[15];
    assign cmd_sel   = grant_b ? cmd_b : cmd_a;

    always_ff @(posedge main_clk) begin
        if (reg_reset) state <= ST_IDLE;
        else           state <= state_d;
    end

    always_comb begin
        state_d   = state;
        grant_a   = 1'b0;
        grant_b   = 1'b0;
        hold_exit = 1'b0;
        case (state)
            ST_IDLE: begin
                // prio_b set means A was served last, so B wins a tie
                grant_a = req_a && (!req_b || !prio_b);
                grant_b = req_b && (!req_a || prio_b);
                if (req_a || req_b) state_d = ST_SETUP;
            end
            ST_SETUP: if (pcnt == DIV_LAST) state_d = ST_SHIFT;
            ST_SHIFT: if (sclk_fall && bit_cnt == BIT_LAST) state_d = ST_HOLD;
            ST_HOLD: begin
                if (pcnt == DIV_LAST) begin
                    hold_exit = 1'b1;
                    state_d   = ST_GAP;
                end
            end
            ST_GAP:   if (pcnt == GAP_LAST) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge main_clk) begin
        if (reg_reset || state_d != state) pcnt <= '0;
        else                               pcnt <= pcnt + 1'b1;
    end

    always_ff @(posedge main_clk) begin
        if (reg_reset) begin
            gnt_a   <= 1'b0;
            gnt_b   <= 1'b0;
            done    <= 1'b0;
            prio_b  <= 1'b0;
            sel_b   <= 1'b0;
            sh      <= '0;
            bit_cnt <= '0;
        end else begin
            gnt_a <= grant_a;
            gnt_b <= grant_b;
            done  <= hold_exit;
            if (grant_a || grant_b) begin
                sh      <= cmd_sel;
                sel_b   <= grant_b;
                prio_b  <= grant_a;
                bit_cnt <= '0;
            end else if (shifting && sclk_fall) begin
                sh      <= {sh[14:0], 1'b0};
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

`ifdef AGC_SPI_READBACK_EN
    localparam logic [4:0] SDIO_FALL   = 5'(FRAME_BITS / 2 - 1);
    localparam logic [4:0] SAMPLE_FROM = 5'(FRAME_BITS / 2);

    logic       is_rd, sdio_q, rd_valid_q;
    logic [7:0] rd_shift, rd_data_q;

    always_ff @(posedge main_clk) begin
        if (reg_reset) begin
            is_rd      <= 1'b0;
            sdio_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_shift   <= '0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= hold_exit && is_rd;
            if (grant_a || grant_b) begin
                is_rd  <= frame_t'(cmd_sel).rw;
                sdio_q <= 1'b0;
            end
            if (shifting && sclk_fall && bit_cnt == SDIO_FALL && is_rd) sdio_q <= 1'b1;
            if (shifting && sclk_rise && bit_cnt >= SAMPLE_FROM)
                rd_shift <= {rd_shift[6:0], spi_miso};
            if (hold_exit) begin
                sdio_q <= 1'b0;
                if (is_rd) rd_data_q <= rd_shift;
            end
        end
    end

    assign sdio_t   = sdio_q;
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
`else
    // MISO and the rise strobe have no consumer in a write-only build
    logic unused_rb;
    assign unused_rb = spi_miso ^ sclk_rise;

    assign sdio_t   = 1'b0;
    assign rd_valid = 1'b0;
    assign rd_data  = '0;
`endif

endmodule

// File: tb/tb_agc_spi_sched.sv
// Self-checking bench for agc_spi_sched: table vectors, corner sequences and randomized frames
// checked against a frame-level monitor and a round-robin model.
module tb_agc_spi_sched;

    logic        clk = 1'b0;
    logic        reg_reset = 1'b0;
    logic        req_a = 1'b0, req_b = 1'b0;
    logic [15:0] cmd_a = '0, cmd_b = '0;
    logic        gnt_a, gnt_b, busy, done, rd_valid;
    logic [7:0]  rd_data;
    logic        spi_sclk, spi_csa_n, spi_csb_n, spi_mosi, sdio_t;
    logic        spi_miso = 1'b0;

    always #5 clk = ~clk;

    agc_spi_sched #(.CLK_DIV(4), .FRAME_BITS(16)) dut (
        .main_clk (clk),
        .reg_reset(reg_reset),
        .req_a    (req_a),
        .req_b    (req_b),
        .cmd_a    (cmd_a),
        .cmd_b    (cmd_b),
        .gnt_a    (gnt_a),
        .gnt_b    (gnt_b),
        .busy     (busy),
        .done     (done),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .spi_sclk (spi_sclk),
        .spi_csa_n(spi_csa_n),
        .spi_csb_n(spi_csb_n),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso),
        .sdio_t   (sdio_t)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Frame-level monitor: accumulates totals, captures MOSI at SCLK rise, plays the MISO slave
    bit          mon_en = 1'b0;
    bit          cur_read = 1'b0;
    logic [7:0]  mb = '0;
    int          cyc_a = 0, cyc_b = 0, done_tot = 0, rdv_tot = 0, gnta_tot = 0, gntb_tot = 0;
    int          sdio_err = 0, bus_err = 0, rdv_err = 0;
    int          rises = 0, falls = 0;
    logic [15:0] mosi_cap = '0;
    logic [7:0]  rd_cap = '0;
    bit          prev_cs = 1'b0, prev_sclk = 1'b0;

    always @(negedge clk) begin
        bit cs_any, exp_sdio;
        if (mon_en) begin
            cs_any = !spi_csa_n || !spi_csb_n;
            if (!spi_csa_n && !spi_csb_n) bus_err++;
            if (!cs_any && spi_sclk !== 1'b0) bus_err++;
            if (cs_any && !prev_cs) begin
                rises = 0; falls = 0; mosi_cap = '0;
            end
            if (!spi_csa_n) cyc_a++;
            if (!spi_csb_n) cyc_b++;
            if (spi_sclk && !prev_sclk) begin
                mosi_cap = {mosi_cap[14:0], spi_mosi};
                rises++;
            end
            if (!spi_sclk && prev_sclk) falls++;
            exp_sdio = cur_read && cs_any && (falls >= 8);
            if (sdio_t !== exp_sdio) sdio_err++;
            if (done) done_tot++;
            if (rd_valid) begin
                rdv_tot++;
                rd_cap = rd_data;
                if (!done) rdv_err++;
            end
            if (gnt_a) gnta_tot++;
            if (gnt_b) gntb_tot++;
            spi_miso = (rises >= 8 && rises < 16) ? mb[15 - rises] : 1'b0;
            prev_cs   = cs_any;
            prev_sclk = spi_sclk;
        end
    end

    bit last_b = 1'b1;   // round-robin model: after reset A has priority

    task automatic do_reset();
        @(negedge clk);
        reg_reset = 1'b1; req_a = 1'b0; req_b = 1'b0;
        @(negedge clk);
        reg_reset = 1'b0;
        last_b = 1'b1;
    endtask

    task automatic frame(input bit ra, input bit rb, input logic [15:0] ca, input logic [15:0] cb,
                         input logic [7:0] byte_in, input bit exp_b, input bit disturb,
                         input string nm);
        logic [15:0] wcmd;
        bit rdf, got;
        int sa, sb, sd, sv, sga, sgb, ss, so;
        wcmd = exp_b ? cb : ca;
`ifdef AGC_SPI_READBACK_EN
        rdf = wcmd[15];
`else
        rdf = 1'b0;
`endif
        @(negedge clk);
        sa = cyc_a; sb = cyc_b; sd = done_tot; sv = rdv_tot;
        sga = gnta_tot; sgb = gntb_tot; ss = sdio_err + rdv_err; so = bus_err;
        cur_read = rdf; mb = byte_in;
        req_a = ra; req_b = rb; cmd_a = ca; cmd_b = cb;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (gnt_a || gnt_b) got = 1'b1;
        end
        chk({nm, " grant"}, {30'd0, gnt_a, gnt_b}, exp_b ? 32'd1 : 32'd2);
        req_a = 1'b0; req_b = 1'b0;
        if (disturb) begin
            repeat (30) @(negedge clk);
            cmd_a = ~ca;
            req_b = 1'b1;
            @(negedge clk);
            req_b = 1'b0;
        end
        for (int i = 0; i < 400 && busy; i++) @(negedge clk);
        chk({nm, " busy_end"}, 32'(busy), 32'd0);
        chk({nm, " cs_cycles"}, exp_b ? 32'(cyc_b - sb) : 32'(cyc_a - sa), 32'd136);
        chk({nm, " other_cs"}, exp_b ? 32'(cyc_a - sa) : 32'(cyc_b - sb), 32'd0);
        chk({nm, " mosi"}, 32'(mosi_cap), 32'(wcmd));
        chk({nm, " done_cnt"}, 32'(done_tot - sd), 32'd1);
        chk({nm, " gnt_win"}, exp_b ? 32'(gntb_tot - sgb) : 32'(gnta_tot - sga), 32'd1);
        chk({nm, " gnt_lose"}, exp_b ? 32'(gnta_tot - sga) : 32'(gntb_tot - sgb), 32'd0);
        chk({nm, " rd_valid_cnt"}, 32'(rdv_tot - sv), 32'(rdf));
        chk({nm, " sdio_rdv"}, 32'(sdio_err + rdv_err - ss), 32'd0);
        chk({nm, " bus"}, 32'(bus_err - so), 32'd0);
        if (rdf) chk({nm, " rd_data"}, 32'(rd_cap), 32'(byte_in));
`ifndef AGC_SPI_READBACK_EN
        chk({nm, " rd_data_tied"}, 32'(rd_data), 32'd0);
`endif
    endtask

    typedef struct {
        bit          ra;
        bit          rb;
        logic [15:0] ca;
        logic [15:0] cb;
        logic [7:0]  mbyte;
        bit          exp_b;
    } vec_t;

    vec_t tbl [7];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit got, ra, rb, eb;
        int sd;
        logic [15:0] ca, cb;

        tbl[0] = '{1'b1, 1'b1, 16'h0A5C, 16'h1234, 8'h00, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 16'h0A5C, 16'h0000, 8'h00, 1'b0};
        tbl[2] = '{1'b1, 1'b1, 16'h4F01, 16'h7E80, 8'h00, 1'b1};
        tbl[3] = '{1'b0, 1'b1, 16'h0000, 16'h8300, 8'hC3, 1'b1};
        tbl[4] = '{1'b1, 1'b1, 16'hD5AA, 16'h0F0F, 8'h3C, 1'b0};
        tbl[5] = '{1'b1, 1'b1, 16'h5555, 16'hFFFF, 8'h00, 1'b1};
        tbl[6] = '{1'b0, 1'b1, 16'hFFFF, 16'h8001, 8'hA5, 1'b1};

        // Reset with a request pending: no grant may leak out
        reg_reset = 1'b1; req_a = 1'b1; cmd_a = 16'h0A5C;
        repeat (3) @(negedge clk);
        chk("reset_state",
            {19'd0, spi_csa_n, spi_csb_n, spi_sclk, spi_mosi, sdio_t, gnt_a, gnt_b, done,
             rd_valid, busy, rd_data},
            {19'd0, 2'b11, 8'b0, 8'h00});
        req_a = 1'b0;
        reg_reset = 1'b0;
        mon_en = 1'b1;
        last_b = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++)
            frame(tbl[i].ra, tbl[i].rb, tbl[i].ca, tbl[i].cb, tbl[i].mbyte, tbl[i].exp_b, 1'b0,
                  $sformatf("vec%0d", i));

        // Latched command must survive cmd_a changes; a busy-time req_b pulse is ignored
        frame(1'b1, 1'b0, 16'h0A5C, 16'h0000, 8'h00, 1'b0, 1'b1, "mid_change");

        // Both held from reset: service alternates A,B,A,B
        do_reset();
        cmd_a = 16'h1111; cmd_b = 16'h2222; cur_read = 1'b0;
        req_a = 1'b1; req_b = 1'b1;
        for (int k = 0; k < 4; k++) begin
            got = 1'b0;
            for (int i = 0; i < 400 && !got; i++) begin
                @(negedge clk);
                if (gnt_a || gnt_b) got = 1'b1;
            end
            chk($sformatf("alt_order%0d", k), {30'd0, gnt_a, gnt_b},
                (k % 2 == 1) ? 32'd1 : 32'd2);
        end
        req_a = 1'b0; req_b = 1'b0;
        for (int i = 0; i < 400 && busy; i++) @(negedge clk);

        // Reset in the middle of SHIFT aborts the frame silently
        @(negedge clk);
        cmd_a = 16'h0A5C; cur_read = 1'b0; req_a = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (gnt_a) got = 1'b1;
        end
        req_a = 1'b0;
        sd = done_tot;
        for (int i = 0; i < 200 && rises < 8; i++) @(negedge clk);
        chk("abort_reached_bit7", 32'(rises >= 8), 32'd1);
        reg_reset = 1'b1;
        @(negedge clk);
        chk("abort_outputs", {27'd0, spi_csa_n, spi_csb_n, spi_sclk, busy, done},
            {27'd0, 5'b11000});
        reg_reset = 1'b0;
        last_b = 1'b1;
        repeat (160) @(negedge clk);
        chk("abort_no_done", 32'(done_tot - sd), 32'd0);
        frame(1'b1, 1'b0, 16'h3C96, 16'h0000, 8'h00, 1'b0, 1'b0, "post_reset");

        // Randomized frames against the round-robin model
        do_reset();
        for (int n = 0; n < 12; n++) begin
            ra = 1'($urandom_range(0, 1));
            rb = 1'($urandom_range(0, 1));
            if (!ra && !rb) ra = 1'b1;
            eb = (ra && rb) ? !last_b : rb;
            ca = 16'($urandom);
            cb = 16'($urandom);
            frame(ra, rb, ca, cb, 8'($urandom), eb, 1'b0, $sformatf("rnd%0d", n));
            last_b = eb;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/agc_spi_sched.md
AGC_SPI_SCHED -- requirements
Module: agc_spi_sched

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 4: SCLK half-period in main_clk cycles; legal range 2..255.
REQ-002 The block SHALL have parameter FRAME_BITS, default 16: bits per SPI frame, fixed at 16 in this release.
REQ-003 main_clk  in  1  sole clock; all logic SHALL be clocked on its rising edge.
REQ-004 reg_reset  in  1  reset; synchronous, active-high.
REQ-005 req_a / req_b  in  1 each  requester A (channel A loop) and requester B (channel B loop) transaction request; level, held until granted.
REQ-006 cmd_a / cmd_b  in  16 each  frame {R1W0[15], addr[14:8], data[7:0]}.
REQ-007 gnt_a / gnt_b  out  1 each  one-cycle pulse when the matching cmd is latched.
REQ-008 busy  out  1  high from grant until the end of GAP.
REQ-009 done  out  1  one-cycle pulse at the end of HOLD.
REQ-010 rd_data  out  8  readback byte; rd_valid  out  1  one-cycle qualifier, coincident with done.
REQ-011 spi_sclk  out  1  serial clock, idle low.
REQ-012 spi_csa_n / spi_csb_n  out  1 each  active-low chip selects, A for requester A, B for requester B.
REQ-013 spi_mosi  out  1; spi_miso  in  1; sdio_t  out  1: 1 = release SDIO pad for read.

Function
REQ-014 States SHALL be IDLE, SETUP, SHIFT, HOLD, GAP.
REQ-015 IDLE: if any req is high, assert the winner's gnt, latch its cmd, and go to SETUP on the next cycle.
REQ-016 Arbitration SHALL be round-robin: on a tie, the requester not served last wins; after reset, A has priority.
REQ-017 SETUP: drive the selected cs_n low and MOSI = bit 15, hold for CLK_DIV cycles, then go to SHIFT.
REQ-018 SHIFT: 16 SCLK periods of 2*CLK_DIV cycles, MSB first; SCLK rises after CLK_DIV low cycles; MOSI updates on the falling edge; MISO is sampled on the rising edge.
REQ-019 Read frame (R1W0=1): after the 8th falling edge, sdio_t=1 until HOLD exits; bits 7..0 are sampled into rd_data.
REQ-020 HOLD: SCLK low and cs_n low for CLK_DIV cycles; then done pulses (rd_valid with it for reads), cs_n goes high, and the state goes to GAP.
REQ-021 GAP: both cs_n high for 2*CLK_DIV cycles, then go to IDLE; with CLK_DIV=4, cs_n is low for exactly 136 cycles per frame.
REQ-022 A req arriving or changing while busy SHALL be ignored until IDLE; the latched cmd SHALL NOT change mid-frame.
REQ-023 A req dropped before grant SHALL be abandoned with no side effect.
REQ-024 Only one cs_n SHALL be low at any time; both cs_n SHALL be high outside SETUP..HOLD.

Reset
REQ-025 When reg_reset=1 at a clock edge, next-cycle values SHALL be: state IDLE, spi_csa_n=spi_csb_n=1, spi_sclk=0, spi_mosi=0, sdio_t=0, gnt_a=gnt_b=done=rd_valid=busy=0, rd_data=0, round-robin pointer favouring A.
REQ-026 Reset mid-frame SHALL abort the frame with no done pulse; cs_n SHALL return high within one cycle.

Configuration
REQ-027 Macro AGC_SPI_READBACK_EN defined: read frames SHALL behave per REQ-019.
REQ-028 AGC_SPI_READBACK_EN undefined: R1W0 SHALL be ignored and every frame treated as a write; sdio_t, rd_valid and rd_data SHALL be tied 0; no MISO sampling logic.

Structure
REQ-029 Package agc_spi_pkg SHALL hold the state enum, frame field positions (R1W0 bit, addr/data slices), and the default CLK_DIV.
REQ-030 Sub-module agc_spi_clkdiv SHALL generate SCLK plus one-cycle rise/fall strobes from CLK_DIV and an enable; the FSM consumes the strobes.

Verification
REQ-031 CLK_DIV=4, req_a with cmd_a=16'h0A5C: gnt_a 1 cycle; spi_csa_n low for 136 cycles; MOSI shifts 0000_1010_0101_1100; done once; spi_csb_n stays 1.
REQ-032 req_a and req_b raised in the same cycle after reset: A served first, then B after GAP; with both held, service alternates A,B,A,B.
REQ-033 Read cmd_b=16'h8300 with MISO model returning 8'hC3: sdio_t high from the 8th falling edge through HOLD; rd_data=8'hC3 with rd_valid coincident with done.
REQ-034 reg_reset asserted at bit 7 of SHIFT: next cycle cs_n high, sclk 0, busy 0, no done; a following request completes normally.
REQ-035 Build without AGC_SPI_READBACK_EN, cmd 16'h8300: sdio_t stays 0, rd_valid never asserts, and the frame is shifted as a write.
REQ-036 cmd_a changed mid-frame: MOSI shows only the value latched at grant; req_b pulsed for 1 cycle while busy produces no grant.
